// File: rtl/base_system_dbg_arb_pkg.sv
// Shared types and constants for the OCI debug memory port arbiter.
package base_system_dbg_arb_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t RESP  = 2'd2;

  typedef logic grant_id_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/base_system_dbg_rr_arbiter2.sv
// Two-way round-robin arbiter; force0 gives requester 0 absolute priority.
module base_system_dbg_rr_arbiter2
  import base_system_dbg_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  grant_id_t  last_grant,
  input  logic       force0,
  output logic [1:0] grant,
  output grant_id_t  grant_id
);

  always_comb begin
    grant = 2'b00;
    if (force0 && valid[0]) begin
      grant = 2'b01;
    end else if (&valid) begin
      // tie goes to whichever requester was not served last
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
    grant_id = grant[1];
  end

endmodule

// File: rtl/system.sv
// Shares the OCI debug memory port between the JTAG command path (0) and the
// trace/host master (1), one outstanding access at a time with ack timeout.
module system
  import base_system_dbg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debugack,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_error,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_error,
  output logic              mem_cs,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  grant_id_t        last_grant_q, gid_q, grant_id;
  logic [1:0]       grant;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             accept, complete, timed_out;
  logic [DATA_W-1:0] rsp_data;

  base_system_dbg_rr_arbiter2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .force0     (debugack),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign cnt_inc = CNT_W'(cnt_q + CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant && !reset) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // an ack landing on the timeout cycle still counts as success
        if (mem_ack) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          complete  = 1'b1;
          timed_out = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = accept & grant[0];
  assign req1_ready = accept & grant[1];
  assign mem_cs     = (state_q == ISSUE);
  assign rsp_data   = (timed_out || mem_write) ? '0 : mem_rdata;

  // capture, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      cnt_q        <= '0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp0_error   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= '0;
      rsp1_error   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (accept) begin
        gid_q     <= grant_id;
        cnt_q     <= '0;
        mem_write <= grant_id ? req1_write : req0_write;
        mem_addr  <= grant_id ? req1_addr  : req0_addr;
        mem_wdata <= grant_id ? req1_wdata : req0_wdata;
      end
      if (state_q == ISSUE && !complete) cnt_q <= cnt_inc;
      if (complete) begin
        if (gid_q) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= rsp_data;
          rsp1_error <= timed_out;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= rsp_data;
          rsp0_error <= timed_out;
        end
      end
      if (state_q == RESP) last_grant_q <= gid_q;
    end
  end

endmodule

// File: tb/tb_system.sv
// Directed bench for the OCI debug memory port arbiter (TIMEOUT=4).
module tb_system;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, debugack;
  logic        req0_valid, req0_write, req0_ready;
  logic [7:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_write, req1_ready;
  logic [7:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp0_error, rsp1_valid, rsp1_error;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_cs, mem_write, mem_ack;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  system #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .debugack(debugack),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_error(rsp1_error),
    .mem_cs(mem_cs), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1; debugack = 1'b0; mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge with requests already driven; returns at the next IDLE negedge.
  // ack_at = 0 means no ack (timeout expected).
  task automatic run_txn(input int g, input logic [7:0] addr, input logic wr,
                         input logic [31:0] wd, input int ack_at,
                         input logic [31:0] rd, input logic drop);
    logic        err;
    logic [31:0] exp_rd;
    int          last;
    err    = (ack_at == 0);
    last   = err ? TO : ack_at;
    exp_rd = (err || wr) ? 32'h0 : rd;
    #1;
    check_eq("rsp_idle", {rsp1_valid, rsp0_valid}, 0);
    check_eq("ready", {req1_ready, req0_ready}, (g == 0) ? 32'h1 : 32'h2);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1 && drop) begin
        if (g == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
      end
      #1;
      check_eq("mem_cs_issue", mem_cs, 1);
      check_eq("ready_issue", {req1_ready, req0_ready}, 0);
      if (c == 1) begin
        check_eq("mem_addr", mem_addr, addr);
        check_eq("mem_write", mem_write, wr);
        check_eq("mem_wdata", mem_wdata, wd);
      end
      if (c == ack_at) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    #1;
    check_eq("mem_cs_resp", mem_cs, 0);
    check_eq("rsp_valid", {rsp1_valid, rsp0_valid}, (g == 0) ? 32'h1 : 32'h2);
    check_eq("rsp_rdata", (g == 0) ? rsp0_rdata : rsp1_rdata, exp_rd);
    check_eq("rsp_error", (g == 0) ? rsp0_error : rsp1_error, err);
    @(negedge clk);
  endtask

  initial begin
    reset_dut();
    #1;
    check_eq("rst_outs", {mem_cs, mem_write, rsp0_valid, rsp1_valid, rsp0_error,
                          rsp1_error, req0_ready, req1_ready}, 0);
    check_eq("rst_buses", mem_addr | mem_wdata | rsp0_rdata | rsp1_rdata, 0);
    @(negedge clk);

    // single read on requester 0, ack at cycle 3
    req0_valid = 1'b1; req0_addr = 8'h05;
    run_txn(0, 8'h05, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b1);
    check_eq("rsp_clear", {rsp1_valid, rsp0_valid}, 0);

    // round-robin alternation with both held valid
    reset_dut();
    req0_valid = 1'b1; req0_addr = 8'h10;
    req1_valid = 1'b1; req1_addr = 8'h20; req1_write = 1'b1; req1_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) run_txn(0, 8'h10, 1'b0, 32'h0, 1, 32'h100 + i, 1'b0);
      else            run_txn(1, 8'h20, 1'b1, 32'h5555_AAAA, 1, 32'h100 + i, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; req1_write = 1'b0;

    // debug mode starves requester 1 until debugack drops
    reset_dut();
    debugack = 1'b1;
    req0_valid = 1'b1; req0_addr = 8'h31;
    req1_valid = 1'b1; req1_addr = 8'h42;
    for (int i = 0; i < 3; i++) run_txn(0, 8'h31, 1'b0, 32'h0, 1, 32'h200 + i, 1'b0);
    debugack = 1'b0;
    run_txn(1, 8'h42, 1'b0, 32'h0, 1, 32'h300, 1'b1);
    req0_valid = 1'b0;

    // timeout, then ack on the timeout cycle
    req0_valid = 1'b1; req0_addr = 8'h40;
    run_txn(0, 8'h40, 1'b0, 32'h0, 0, 32'h0, 1'b1);
    req0_valid = 1'b1; req0_addr = 8'h41;
    run_txn(0, 8'h41, 1'b0, 32'h0, TO, 32'h0BAD_F00D, 1'b1);

    // write via requester 1, then a spurious ack in IDLE
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 8'h08; req1_wdata = 32'h1234_5678;
    run_txn(1, 8'h08, 1'b1, 32'h1234_5678, 2, 32'hFFFF_FFFF, 1'b1);
    req1_write = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check_eq("spurious_ack", {mem_cs, rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);

    // reset mid-ISSUE drops the transaction; last_grant returns to 1
    reset_dut();
    req0_valid = 1'b1; req0_addr = 8'h01;
    run_txn(0, 8'h01, 1'b0, 32'h0, 1, 32'h11, 1'b1);
    req1_valid = 1'b1; req1_addr = 8'h77; req1_write = 1'b1; req1_wdata = 32'h0000_CAFE;
    #1;
    check_eq("r1_ready", {req1_ready, req0_ready}, 2);
    @(negedge clk);
    #1;
    check_eq("r1_issue", mem_cs, 1);
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b1; req0_addr = 8'h33;
    #1;
    check_eq("ready_in_rst", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_outs", {mem_cs, mem_write, rsp0_valid, rsp1_valid}, 0);
    check_eq("rst_mid_bus", mem_addr | mem_wdata, 0);
    run_txn(0, 8'h33, 1'b0, 32'h0, 1, 32'h33, 1'b1);
    run_txn(1, 8'h77, 1'b1, 32'h0000_CAFE, 2, 32'h44, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
